// File: rtl/debug_bit_overlay.sv
`default_nettype none
// ============================================================================
// Module      : debug_bit_overlay
// Description : Draws CHANNELS debug words as a grid of coloured bit cells for
//               the vga colour input, with live/freeze snapshots, change
//               highlighting and an LED mirror of one channel.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_bit_overlay #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 16,
    parameter int CELL_W_LOG2 = 4,
    parameter int CELL_H_LOG2 = 5,
    parameter int X_ORG       = 16,
    parameter int Y_ORG       = 16,
    parameter int LED_CH      = 0
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic [15:0]               pix_x,
    input  logic [15:0]               pix_y,
    input  logic [CHANNELS*WIDTH-1:0] dbg_data,
    input  logic                      freeze,
    input  logic                      snap_req,
    output logic                      snap_ack,
    output logic [15:0]               col,
    output logic [9:0]                leds
);

    localparam int          c_bits  = CHANNELS * WIDTH;
    localparam int          c_idx_w = (c_bits > 1) ? $clog2(c_bits) : 1;
    localparam logic [15:0] c_x_org = 16'(X_ORG);
    localparam logic [15:0] c_y_org = 16'(Y_ORG);

    localparam logic [0:0]  c_st_idle  = 1'b0;
    localparam logic [0:0]  c_st_armed = 1'b1;

    logic [0:0]          r_state;
    logic                r_was_origin;
    logic [c_bits-1:0]   r_snap;
    logic [c_bits-1:0]   r_chg;
    logic                r_snap_ack;
    logic [15:0]         r_col;
    logic [9:0]          r_leds;

    logic                w_at_origin;
    logic                w_fs;
    logic                w_capture;
    logic [9:0]          w_led_word;
    logic [15:0]         w_dx;
    logic [15:0]         w_dy;
    logic [15:0]         w_cx;
    logic [15:0]         w_row;
    logic                w_in;
    logic                w_inside;
    logic                w_border;
    logic [c_idx_w-1:0]  w_sel;
    logic [11:0]         w_colour;

    // The origin pixel may be held for several clocks; only its first cycle is a frame start.
    assign w_at_origin = (pix_x == 16'd0) && (pix_y == 16'd0);
    assign w_fs        = w_at_origin && !r_was_origin;

    assign w_capture = w_fs && ((r_state == c_st_armed) ||
                                (r_state == c_st_idle && !freeze));

    generate
        if (WIDTH < 10) begin : g_led_narrow
            assign w_led_word = 10'(dbg_data[LED_CH*WIDTH +: WIDTH]);
        end else begin : g_led_wide
            assign w_led_word = dbg_data[LED_CH*WIDTH +: 10];
        end
    endgenerate

    // Pixels left of or above the origin wrap dx/dy, so w_in must gate the cell test.
    assign w_dx     = pix_x - c_x_org;
    assign w_dy     = pix_y - c_y_org;
    assign w_in     = (pix_x >= c_x_org) && (pix_y >= c_y_org);
    assign w_cx     = w_dx >> CELL_W_LOG2;
    assign w_row    = w_dy >> CELL_H_LOG2;
    assign w_inside = w_in && ({16'd0, w_cx} < 32'(WIDTH)) &&
                      ({16'd0, w_row} < 32'(CHANNELS));
    assign w_border = w_inside && ((w_dx[CELL_W_LOG2-1:0] == '0) ||
                                   (w_dy[CELL_H_LOG2-1:0] == '0));

    assign w_sel = w_inside
                 ? c_idx_w'(({16'd0, w_row} * 32'(WIDTH)) + 32'(WIDTH - 1) - {16'd0, w_cx})
                 : '0;

    always_comb begin
        w_colour = {pix_x[3:0], 8'h00};
        if (w_inside) begin
            if (w_border) begin
                w_colour = 12'h000;
            end else if (r_chg[w_sel]) begin
                w_colour = 12'hFF0;
            end else if (r_snap[w_sel]) begin
                w_colour = 12'h0F0;
            end else begin
                w_colour = 12'h300;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state      <= c_st_idle;
            r_was_origin <= 1'b0;
            r_snap       <= '0;
            r_chg        <= '0;
            r_snap_ack   <= 1'b0;
            r_col        <= '0;
            r_leds       <= '0;
        end else begin
            r_was_origin <= w_at_origin;
            r_snap_ack   <= w_capture;
            r_col        <= {4'h0, w_colour};

            case (r_state)
                c_st_idle: begin
                    // An arm request coinciding with fs defers the capture to the next frame.
                    if (freeze && snap_req) begin
                        r_state <= c_st_armed;
                    end
                end
                c_st_armed: begin
                    if (w_fs) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase

            if (w_capture) begin
                r_snap <= dbg_data;
                r_chg  <= r_snap ^ dbg_data;
                r_leds <= w_led_word;
            end
        end
    end

    assign snap_ack = r_snap_ack;
    assign col      = r_col;
    assign leds     = r_leds;

endmodule
`default_nettype wire
